mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter that shares one unified instruction/data RAM between the CPU's instruction-fetch port and its load/store data port. It sits between the CPU core and the RAM macro. It serialises one transaction at a time through a small FSM, absorbs a fixed RAM read latency, and returns registered read data with a one-cycle acknowledge. Data accesses have priority; an optional starvation guard periodically forces a fetch grant.

## Interface
Parameters:
- AW, 32: address width.
- DW, 32: data width.
- RD_LAT, 1: RAM read latency in cycles (legal 1..4).
- STARVE_LIM, 4: consecutive data grants tolerated while fetch waits (used only with the guard).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request; held until if_ack.
- if_addr  in  AW  fetch address.
- if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid.
- if_rdata  out  DW  fetched word, registered; holds until next fetch completes.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_ack  out  1  one-cycle pulse: data access complete.
- d_rdata  out  DW  load data, registered; holds until next data read completes.
- mem_en  out  1  RAM access strobe, one cycle per transaction.
- mem_we  out  1  RAM write enable, qualified by mem_en.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid RD_LAT cycles after mem_en.

## Operation
- Four-state FSM:
  - IDLE: arbitrate among the sampled requests.
  - ISSUE: drive the RAM for one cycle.
  - WAIT: count RD_LAT cycles, then capture mem_rdata.
  - RESP: pulse the acknowledge.
- IDLE:
  - With no request, stay in IDLE.
  - Otherwise latch owner, address, we and wdata, then go to ISSUE.
  - Fetch requests are always reads; the latched we is 0 for fetch.
- Arbitration: d_req wins over if_req, subject to the starvation guard.
- ISSUE: mem_en=1; mem_addr, mem_we and mem_wdata come from the latched registers.
  - Write: d_ack=1 in this same cycle, then go to IDLE.
  - Read: go to WAIT.
- WAIT: stays RD_LAT cycles. On its last cycle, capture mem_rdata into the owner's rdata register, then go to RESP.
- RESP: the owner's ack=1 for one cycle, then go to IDLE.
- Exactly one transaction is outstanding at a time. No pipelining.
- The requester must deassert req, or present a new request, only after ack. The arbiter re-samples req only in IDLE.
- If req drops mid-transaction, the arbiter still completes the transaction and still pulses ack.
- The non-owner's rdata and ack are never disturbed.
- A write never updates d_rdata.
- mem_we=0 and mem_wdata=0 whenever mem_en=0.

## Timing
- All outputs are registered.
- Reset values: state=IDLE; every output is 0 (if_ack, d_ack, if_rdata, d_rdata, mem_en, mem_we, mem_addr, mem_wdata); starvation counter = 0.
- Request first asserted in cycle 0:
  - ISSUE is cycle 1.
  - Write ack is in cycle 1.
  - Read ack is in cycle RD_LAT+2.
- A request that is held continuously completes its read in RD_LAT+3 cycles, including the return to IDLE.
- Simultaneous if_req and d_req in IDLE: data is served first. Fetch is served on the next IDLE visit.
- Reset asserted in any state (e.g. mid-WAIT):
  - Next cycle is IDLE with all outputs at their reset values.
  - The in-flight transaction is dropped and no ack is issued.
  - RAM read data arriving later is ignored.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A counter increments on each data grant made while if_req=1.
  - When the counter equals STARVE_LIM and both requests are pending in IDLE, fetch is granted and the counter clears.
  - Any fetch grant clears the counter.
- Undefined: strict data priority; no counter logic is present.

## Test plan
- RD_LAT=1, if_req at 0x100, RAM returns 0xE3A01005 → mem_en=1 with mem_addr=0x100 in cycle 1 only; if_ack with if_rdata=0xE3A01005 in cycle 3.
- d_req write, addr 0x40, data 0xDEADBEEF → mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF in cycle 1; d_ack in cycle 1; d_rdata unchanged (0).
- RD_LAT=1, if_req and d_req (read 0x80) both asserted in cycle 0 → d_ack in cycle 3; fetch ISSUE in cycle 5; if_ack in cycle 7.
- RD_LAT=3, data read → d_ack in cycle 5; d_rdata equals the mem_rdata value sampled in cycle 4.
- ARB_STARVE_GUARD_EN, STARVE_LIM=2, continuous d_req writes with if_req held → grant order D, D, F, D, D, F. Without the macro → D every time and no if_ack.
- Reset pulsed in the WAIT cycle of a read → no ack, all outputs 0 next cycle; re-issued request completes normally with correct data.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU ports, the arbiter and the RAM macro.
// The slave modport is the arbiter's view. The master modport is the view
// of the surrounding CPU/RAM environment.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store ports.
// Data has priority over fetch, and only one transaction is in flight at a time.
// Optional starvation guard: define ARB_STARVE_GUARD_EN. After STARVE_LIM data
// grants that overtook a waiting fetch, the guard forces one fetch grant.
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic           clk,
  input  logic           reset,
  mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state;
  logic       owner_fetch;
  logic [2:0] wait_cnt;
  logic       grant_fetch;

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("mem_arbiter: RD_LAT must be in 1..4");
  end

  if (STARVE_LIM < 1) begin : g_bad_starve_lim
    $error("mem_arbiter: STARVE_LIM must be at least 1");
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIM + 1);

  logic [CW-1:0] starve_cnt;
  logic          force_fetch;

  assign force_fetch = bus.if_req && bus.d_req && (starve_cnt == CW'(STARVE_LIM));
  assign grant_fetch = bus.if_req && (!bus.d_req || force_fetch);
`else
  assign grant_fetch = bus.if_req && !bus.d_req;
`endif

  // Transaction FSM: arbitrate, strobe the RAM once, absorb latency, acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      owner_fetch   <= 1'b0;
      wait_cnt      <= 3'd0;
      bus.if_ack    <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.if_rdata  <= {DW{1'b0}};
      bus.d_rdata   <= {DW{1'b0}};
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= {AW{1'b0}};
      bus.mem_wdata <= {DW{1'b0}};
`ifdef ARB_STARVE_GUARD_EN
      starve_cnt    <= '0;
`endif
    end else begin
      bus.if_ack <= 1'b0;
      bus.d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.if_req || bus.d_req) begin
            owner_fetch   <= grant_fetch;
            bus.mem_en    <= 1'b1;
            bus.mem_addr  <= grant_fetch ? bus.if_addr : bus.d_addr;
            bus.mem_we    <= !grant_fetch && bus.d_we;
            bus.mem_wdata <= (!grant_fetch && bus.d_we) ? bus.d_wdata : {DW{1'b0}};
            bus.d_ack     <= !grant_fetch && bus.d_we;
            state         <= ISSUE;
`ifdef ARB_STARVE_GUARD_EN
            if (grant_fetch) begin
              starve_cnt <= '0;
            end else if (bus.if_req) begin
              starve_cnt <= starve_cnt + CW'(1);
            end
`endif
          end
        end
        ISSUE: begin
          bus.mem_en    <= 1'b0;
          bus.mem_we    <= 1'b0;
          bus.mem_addr  <= {AW{1'b0}};
          bus.mem_wdata <= {DW{1'b0}};
          wait_cnt      <= 3'(RD_LAT - 1);
          state         <= bus.mem_we ? IDLE : WAIT;
        end
        WAIT: begin
          if (wait_cnt == 3'd0) begin
            if (owner_fetch) begin
              bus.if_rdata <= bus.mem_rdata;
              bus.if_ack   <= 1'b1;
            end else begin
              bus.d_rdata  <= bus.mem_rdata;
              bus.d_ack    <= 1'b1;
            end
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter. It uses an RD_LAT=1 instance for most
// scenarios and an RD_LAT=3 instance for the latency case. Expected results
// are queued as requests are driven and popped as acknowledges appear.
module tb_mem_arbiter;
  localparam int RD1 = 1;
  localparam int RD3 = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(32), .DW(32)) b1 ();
  mem_arbiter_if #(.AW(32), .DW(32)) b3 ();

  mem_arbiter #(.AW(32), .DW(32), .RD_LAT(RD1), .STARVE_LIM(2)) dut1 (
    .clk(clk), .reset(reset), .bus(b1.slave)
  );

  mem_arbiter #(.AW(32), .DW(32), .RD_LAT(RD3), .STARVE_LIM(2)) dut3 (
    .clk(clk), .reset(reset), .bus(b3.slave)
  );

  int checks = 0;
  int fails = 0;
  int cyc = 0;

  logic [31:0] ram [logic [31:0]];
  logic [31:0] exp_mem [logic [31:0]];
  logic [31:0] pipe1 [RD1];
  logic [31:0] pipe3 [RD3];

  logic [31:0] fetch_q [$];
  logic [31:0] data_q [$];
  bit          dwr_q [$];
  byte         grant_log [$];

  int          last_en_cyc, en_count, last_f_en_cyc, f_ack_cyc, d_ack_cyc, f_ack_count, wr_seq;
  logic [31:0] last_en_addr, last_en_wdata;
  logic        last_en_we;
  bit          f_hold, d_hold;
  logic [31:0] model_f_rdata, model_d_rdata;

  function automatic logic [31:0] initVal(input logic [31:0] a);
    if (a == 32'h100) return 32'hE3A01005;
    return 32'hC0DE0000 ^ a;
  endfunction

  function automatic logic [31:0] ramRead(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return initVal(a);
  endfunction

  function automatic logic [31:0] expRead(input logic [31:0] a);
    if (exp_mem.exists(a)) return exp_mem[a];
    return initVal(a);
  endfunction

  // RAM model for the RD_LAT=1 instance.
  always @(posedge clk) begin
    if (b1.mem_en && b1.mem_we) ram[b1.mem_addr] = b1.mem_wdata;
    pipe1[0] <= (b1.mem_en && !b1.mem_we) ? ramRead(b1.mem_addr) : 32'h5A5A5A5A;
    for (int i = 1; i < RD1; i++) pipe1[i] <= pipe1[i-1];
  end
  assign b1.mem_rdata = pipe1[RD1-1];

  // Read-only RAM model for the RD_LAT=3 instance.
  always @(posedge clk) begin
    pipe3[0] <= (b3.mem_en && !b3.mem_we) ? (b3.mem_addr ^ 32'h5EED0000) : 32'h5A5A5A5A;
    for (int i = 1; i < RD3; i++) pipe3[i] <= pipe3[i-1];
  end
  assign b3.mem_rdata = pipe3[RD3-1];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit fetch, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata);
    if (fetch) begin
      b1.if_req  = 1'b1;
      b1.if_addr = addr;
      fetch_q.push_back(expRead(addr));
    end else begin
      b1.d_req   = 1'b1;
      b1.d_we    = we;
      b1.d_addr  = addr;
      b1.d_wdata = wdata;
      if (we) exp_mem[addr] = wdata;
      data_q.push_back(we ? 32'h0 : expRead(addr));
      dwr_q.push_back(we);
    end
  endtask

  task automatic stepCycle();
    bit          wr;
    logic [31:0] v;
    @(negedge clk);
    cyc++;
    if (b1.mem_en) begin
      en_count++;
      last_en_cyc   = cyc;
      last_en_addr  = b1.mem_addr;
      last_en_we    = b1.mem_we;
      last_en_wdata = b1.mem_wdata;
      if (b1.if_req && !b1.mem_we && b1.mem_addr == b1.if_addr) begin
        grant_log.push_back("F");
        last_f_en_cyc = cyc;
      end else begin
        grant_log.push_back("D");
      end
    end else begin
      checkOutput("mem_we_when_idle", {31'b0, b1.mem_we}, 32'h0);
      checkOutput("mem_wdata_when_idle", b1.mem_wdata, 32'h0);
    end
    if (!b1.if_ack) checkOutput("if_rdata_hold", b1.if_rdata, model_f_rdata);
    if (!b1.d_ack) checkOutput("d_rdata_hold", b1.d_rdata, model_d_rdata);
    if (b1.if_ack) begin
      f_ack_cyc = cyc;
      f_ack_count++;
      if (fetch_q.size() == 0) begin
        checkOutput("if_ack_unexpected", 32'h1, 32'h0);
      end else begin
        model_f_rdata = fetch_q.pop_front();
        checkOutput("if_rdata", b1.if_rdata, model_f_rdata);
      end
      if (f_hold) applyStimulus(1'b1, 1'b0, b1.if_addr, 32'h0);
      else b1.if_req = 1'b0;
    end
    if (b1.d_ack) begin
      d_ack_cyc = cyc;
      if (data_q.size() == 0) begin
        checkOutput("d_ack_unexpected", 32'h1, 32'h0);
      end else begin
        wr = dwr_q.pop_front();
        v  = data_q.pop_front();
        if (wr) begin
          checkOutput("d_rdata_after_write", b1.d_rdata, model_d_rdata);
        end else begin
          model_d_rdata = v;
          checkOutput("d_rdata", b1.d_rdata, model_d_rdata);
        end
      end
      if (d_hold) begin
        wr_seq++;
        applyStimulus(1'b0, 1'b1, 32'h200 + 32'(wr_seq * 4), 32'hA0000000 + 32'(wr_seq));
      end else begin
        b1.d_req = 1'b0;
      end
    end
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n = 0;
    while ((fetch_q.size() != 0 || data_q.size() != 0) && n < budget) begin
      stepCycle();
      n++;
    end
    if (fetch_q.size() != 0 || data_q.size() != 0) begin
      checkOutput({tag, "_timeout"}, 32'h0, 32'h1);
      fetch_q.delete();
      data_q.delete();
      dwr_q.delete();
      b1.if_req = 1'b0;
      b1.d_req  = 1'b0;
    end
    stepCycle();
    stepCycle();
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_if_ack"},    32'(b1.if_ack), 32'h0);
    checkOutput({tag, "_d_ack"},     32'(b1.d_ack), 32'h0);
    checkOutput({tag, "_if_rdata"},  b1.if_rdata, 32'h0);
    checkOutput({tag, "_d_rdata"},   b1.d_rdata, 32'h0);
    checkOutput({tag, "_mem_en"},    32'(b1.mem_en), 32'h0);
    checkOutput({tag, "_mem_we"},    32'(b1.mem_we), 32'h0);
    checkOutput({tag, "_mem_addr"},  b1.mem_addr, 32'h0);
    checkOutput({tag, "_mem_wdata"}, b1.mem_wdata, 32'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          t0, n, ack3;
    logic [31:0] s4;
    bit          got;
    string       exp_seq;
    logic [31:0] g;

    b1.if_req = 1'b0; b1.if_addr = 32'h0; b1.d_req = 1'b0; b1.d_we = 1'b0;
    b1.d_addr = 32'h0; b1.d_wdata = 32'h0;
    b3.if_req = 1'b0; b3.if_addr = 32'h0; b3.d_req = 1'b0; b3.d_we = 1'b0;
    b3.d_addr = 32'h0; b3.d_wdata = 32'h0;
    f_hold = 1'b0; d_hold = 1'b0; wr_seq = 0; f_ack_count = 0;
    model_f_rdata = 32'h0; model_d_rdata = 32'h0;
    last_en_cyc = -1; last_f_en_cyc = -1; f_ack_cyc = -1; d_ack_cyc = -1;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkReset("reset");
    checkOutput("reset_dut3_mem_en", 32'(b3.mem_en), 32'h0);
    reset = 1'b0;

    $display("[TB] fetch read at 0x100");
    en_count = 0;
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0);
    t0 = cyc;
    waitDone("fetch", 20);
    checkOutput("fetch_en_cycle", 32'(last_en_cyc - t0), 32'd1);
    checkOutput("fetch_en_count", 32'(en_count), 32'd1);
    checkOutput("fetch_mem_addr", last_en_addr, 32'h100);
    checkOutput("fetch_ack_cycle", 32'(f_ack_cyc - t0), 32'd3);

    $display("[TB] data write at 0x40");
    en_count = 0;
    applyStimulus(1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
    t0 = cyc;
    waitDone("write", 20);
    checkOutput("write_en_cycle", 32'(last_en_cyc - t0), 32'd1);
    checkOutput("write_en_count", 32'(en_count), 32'd1);
    checkOutput("write_mem_we", 32'(last_en_we), 32'h1);
    checkOutput("write_mem_wdata", last_en_wdata, 32'hDEADBEEF);
    checkOutput("write_mem_addr", last_en_addr, 32'h40);
    checkOutput("write_ack_cycle", 32'(d_ack_cyc - t0), 32'd1);

    $display("[TB] data read back of 0x40");
    applyStimulus(1'b0, 1'b0, 32'h40, 32'h0);
    t0 = cyc;
    waitDone("readback", 20);
    checkOutput("readback_ack_cycle", 32'(d_ack_cyc - t0), 32'd3);

    $display("[TB] simultaneous fetch and data read");
    applyStimulus(1'b1, 1'b0, 32'h104, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h80, 32'h0);
    t0 = cyc;
    waitDone("both", 30);
    checkOutput("both_d_ack_cycle", 32'(d_ack_cyc - t0), 32'd3);
    checkOutput("both_f_issue_cycle", 32'(last_f_en_cyc - t0), 32'd5);
    checkOutput("both_f_ack_cycle", 32'(f_ack_cyc - t0), 32'd7);

    $display("[TB] data read with RD_LAT=3");
    b3.d_req = 1'b1; b3.d_we = 1'b0; b3.d_addr = 32'h20;
    t0 = cyc; n = 0; got = 1'b0; ack3 = -1; s4 = 32'h0;
    while (!got && n < 20) begin
      stepCycle();
      n++;
      if (cyc - t0 == 4) s4 = b3.mem_rdata;
      if (b3.d_ack) begin
        got = 1'b1;
        ack3 = cyc - t0;
        b3.d_req = 1'b0;
      end
    end
    checkOutput("lat3_ack_cycle", 32'(ack3), 32'd5);
    checkOutput("lat3_rdata_vs_mem", b3.d_rdata, s4);
    checkOutput("lat3_rdata", b3.d_rdata, 32'h20 ^ 32'h5EED0000);
    b3.d_req = 1'b0;

    $display("[TB] continuous writes with fetch held");
    grant_log.delete();
    f_ack_count = 0;
    f_hold = 1'b1;
    d_hold = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h108, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h200, 32'hA0000000);
    n = 0;
    while (grant_log.size() < 6 && n < 80) begin
      stepCycle();
      n++;
    end
    f_hold = 1'b0;
    d_hold = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    exp_seq = "DDFDDF";
    checkOutput("starve_if_ack_count", 32'(f_ack_count), 32'd1);
`else
    exp_seq = "DDDDDD";
    checkOutput("starve_if_ack_count", 32'(f_ack_count), 32'd0);
`endif
    for (int i = 0; i < 6; i++) begin
      g = (i < grant_log.size()) ? 32'(grant_log[i]) : 32'h3F;
      checkOutput($sformatf("grant_%0d", i), g, 32'(exp_seq[i]));
    end
    waitDone("starve_drain", 60);

    $display("[TB] reset during WAIT");
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0);
    t0 = cyc;
    stepCycle();
    stepCycle();
    reset = 1'b1;
    fetch_q.delete();
    b1.if_req = 1'b0;
    model_f_rdata = 32'h0;
    model_d_rdata = 32'h0;
    stepCycle();
    checkReset("wait_reset");
    reset = 1'b0;
    repeat (4) stepCycle();
    applyStimulus(1'b1, 1'b0, 32'h10C, 32'h0);
    t0 = cyc;
    waitDone("after_reset", 20);
    checkOutput("after_reset_ack_cycle", 32'(f_ack_cyc - t0), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
